// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : aes_pkg                                                         |
// | Purpose  : Shared AES definitions: round count from key length, FSM state  |
// |            encoding, byte-order constants, S-box and GF(2^8) helpers.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  // Iterative core sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_state_e;

  // Byte order: FIPS-197 byte i of a block sits at bits [c_BYTE0_MSB-8*i -: 8],
  // bytes filled column-major (byte i is row i%4, column i/4).
  localparam int c_BLOCK_BYTES = 16;
  localparam int c_ROWS        = 4;
  localparam int c_BYTE0_MSB   = 127;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [0:255][7:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Number of rounds for a key length; 0 flags an unsupported length.
  function automatic int nr_from_key_bits(input int key_bits);
    case (key_bits)
      128:     return 10;
      192:     return 12;
      256:     return 14;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return c_SBOX[b];
  endfunction

  // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 0x03 in GF(2^8).
  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_comb.sv
// +----------------------------------------------------------------------------+
// | Module   : aes_round_comb                                                  |
// | Purpose  : One combinational AES encryption round: SubBytes, ShiftRows,    |
// |            MixColumns (bypassed on the final round) and AddRoundKey.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_round_comb (
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_final,
  output logic [127:0] o_state
);
  import aes_pkg::*;

  logic [127:0] w_sr;  // after SubBytes + ShiftRows
  logic [127:0] w_mc;  // after MixColumns

  // ShiftRows rotates row r left by r, so output (r,c) takes input (r,(c+r)%4).
  for (genvar gi = 0; gi < c_BLOCK_BYTES; gi++) begin : g_sub_shift
    localparam int c_ROW = gi % c_ROWS;
    localparam int c_COL = gi / c_ROWS;
    localparam int c_SRC = c_ROW + c_ROWS * ((c_COL + c_ROW) % c_ROWS);
    assign w_sr[c_BYTE0_MSB - 8*gi -: 8] = sbox(i_state[c_BYTE0_MSB - 8*c_SRC -: 8]);
  end

  for (genvar gc = 0; gc < c_ROWS; gc++) begin : g_mix
    localparam int c_MSB = c_BYTE0_MSB - 32*gc;
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_sr[c_MSB      -: 8];
    assign w_a1 = w_sr[c_MSB - 8  -: 8];
    assign w_a2 = w_sr[c_MSB - 16 -: 8];
    assign w_a3 = w_sr[c_MSB - 24 -: 8];
    assign w_mc[c_MSB -: 32] = {
      xtime(w_a0) ^ gmul3(w_a1) ^ w_a2        ^ w_a3,
      w_a0        ^ xtime(w_a1) ^ gmul3(w_a2) ^ w_a3,
      w_a0        ^ w_a1        ^ xtime(w_a2) ^ gmul3(w_a3),
      gmul3(w_a0) ^ w_a1        ^ w_a2        ^ xtime(w_a3)
    };
  end

  assign o_state = (i_final ? w_sr : w_mc) ^ i_rk;

endmodule

`default_nettype wire

// File: rtl/aes_iter_core.sv
// +----------------------------------------------------------------------------+
// | Module   : aes_iter_core                                                   |
// | Purpose  : Iterative AES encryption core, one round per clock, round keys  |
// |            fetched from an external key store via rk_idx/rk_i.             |
// |            Define AES_ITER_CTR_EN to add a CTR-mode counter (ctr_load,     |
// |            ctr_iv ports); otherwise the core performs plain ECB.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_iter_core #(
  parameter int KEY_BITS = 256,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_block,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_block,
  output logic                busy
`ifdef AES_ITER_CTR_EN
  ,
  input  logic                ctr_load,
  input  logic [127:0]        ctr_iv
`endif
);
  import aes_pkg::*;

  localparam int                  c_NR   = nr_from_key_bits(KEY_BITS);
  localparam logic [RK_IDX_W-1:0] c_LAST = RK_IDX_W'(c_NR);

  if (c_NR == 0) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
  end
  if ((1 << RK_IDX_W) <= c_NR) begin : g_bad_rk_idx_w
    $error("aes_iter_core: RK_IDX_W too narrow for the round count");
  end

  aes_state_e          r_state, w_state_nxt;
  logic [RK_IDX_W-1:0] r_round;
  logic [127:0]        r_data;
  logic [127:0]        w_round_out;
  logic [127:0]        w_load_blk;
  logic                w_accept;
  logic                w_final;

  assign w_final   = (r_round == c_LAST);
  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);

  aes_round_comb u_round (
    .i_state (r_data),
    .i_rk    (rk_i),
    .i_final (w_final),
    .o_state (w_round_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, accept strobe and round-key index request.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    rk_idx      = '0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        rk_idx = r_round;
        if (w_final) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Whitening on accept, then one round per cycle; the counter parks at 0 after the last round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_round <= '0;
    end else if (w_accept) begin
      r_data  <= w_load_blk ^ rk_i;
      r_round <= RK_IDX_W'(1);
    end else if (r_state == ST_ROUND) begin
      r_data  <= w_round_out;
      r_round <= w_final ? '0 : r_round + 1'b1;
    end
  end

`ifdef AES_ITER_CTR_EN
  logic [127:0] r_ctr;
  logic [127:0] r_xor;
  logic [127:0] w_ctr_cur;

  // A load in the accept cycle takes priority over the stored counter.
  assign w_ctr_cur  = ctr_load ? ctr_iv : r_ctr;
  assign w_load_blk = w_ctr_cur;
  assign out_block  = r_data ^ r_xor;

  // Counter advances its low word on each accept; a load while busy only updates the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctr <= '0;
      r_xor <= '0;
    end else if (w_accept) begin
      r_ctr <= {w_ctr_cur[127:32], w_ctr_cur[31:0] + 32'd1};
      r_xor <= in_block;
    end else if (ctr_load) begin
      r_ctr <= ctr_iv;
    end
  end
`else
  assign w_load_blk = in_block;
  assign out_block  = r_data;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_iter_core.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_iter_core                                                |
// | Purpose  : Directed self-checking bench for aes_iter_core (AES-256 and     |
// |            AES-128 instances, external key store modelled here).           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aes_iter_core;
  import aes_pkg::*;

  localparam int           c_NR256 = 14;
  localparam int           c_NR128 = 10;
  localparam logic [127:0] c_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] c_CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   in_valid, in_ready, out_valid, busy;
  logic         out_ready;
  logic [127:0] in_block, out_block0, out_block1, rk0, rk1;
  logic [3:0]   rk_idx0, rk_idx1;
`ifdef AES_ITER_CTR_EN
  logic         ctr_load;
  logic [127:0] ctr_iv;
`endif

  logic [127:0] ks256 [16];
  logic [127:0] ks128 [16];
  logic [31:0]  kw    [60];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External key stores answer combinationally.
  assign rk0 = ks256[rk_idx0];
  assign rk1 = ks128[rk_idx1];

  aes_iter_core #(.KEY_BITS(256), .RK_IDX_W(4)) u_dut256 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_block(in_block), .rk_idx(rk_idx0), .rk_i(rk0), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_block(out_block0), .busy(busy[0])
`ifdef AES_ITER_CTR_EN
    , .ctr_load(ctr_load), .ctr_iv(ctr_iv)
`endif
  );

  aes_iter_core #(.KEY_BITS(128), .RK_IDX_W(4)) u_dut128 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_block(in_block), .rk_idx(rk_idx1), .rk_i(rk1), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_block(out_block1), .busy(busy[1])
`ifdef AES_ITER_CTR_EN
    , .ctr_load(ctr_load), .ctr_iv(ctr_iv)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIPS-197 key expansion into kw[]; key is left-aligned in 256 bits.
  task automatic expand_key(input int key_bits, input logic [255:0] key);
    int nk, total;
    logic [31:0] t;
    logic [7:0]  rc;
    nk    = key_bits / 32;
    total = 4 * (nk + 7);
    rc    = 8'h01;
    for (int i = 0; i < total; i++) begin
      if (i < nk) begin
        kw[i] = key[255 - 32*i -: 32];
      end else begin
        t = kw[i-1];
        if (i % nk == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
          t = t ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        end
        kw[i] = kw[i-nk] ^ t;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] outb(input int d);
    return (d != 0) ? out_block1 : out_block0;
  endfunction

  function automatic logic [3:0] rkidx(input int d);
    return (d != 0) ? rk_idx1 : rk_idx0;
  endfunction

  // Offer a block whose cipher input is blk (in CTR builds via a counter load, data 0).
  task automatic start_block(input int d, input logic [127:0] blk);
`ifdef AES_ITER_CTR_EN
    ctr_load = 1'b1;
    ctr_iv   = blk;
    in_block = '0;
`else
    in_block = blk;
`endif
    in_valid[d] = 1'b1;
  endtask

  task automatic drop();
    in_valid = '0;
`ifdef AES_ITER_CTR_EN
    ctr_load = 1'b0;
`endif
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Push one block into an idle DUT; lat counts edges from the accept edge (inclusive) to out_valid.
  task automatic run_block(input int d, input logic [127:0] blk,
                           output logic [127:0] res, output int lat);
    start_block(d, blk);
    tick();
    drop();
    lat = 1;
    while (!out_valid[d] && lat < 40) begin
      tick();
      lat++;
      if (lat == 5) begin
        chk("mid_rk_idx", rkidx(d), 5);
        chk("mid_in_ready", in_ready[d], 0);
      end
    end
    res = outb(d);
  endtask

`ifdef AES_ITER_CTR_EN
  task automatic run_ctr(input logic ld, input logic [127:0] iv, input logic [127:0] data,
                         output logic [127:0] res);
    int n;
    ctr_load = ld;
    ctr_iv   = iv;
    in_block = data;
    in_valid[0] = 1'b1;
    tick();
    drop();
    n = 0;
    while (!out_valid[0] && n < 40) begin
      tick();
      n++;
    end
    chk("ctr_done_seen", out_valid[0], 1);
    res = out_block0;
    handshake();
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] res;
    int           lat;
    int           seen;
    int           acc [$];
    int           n_out;

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    in_block  = '0;
`ifdef AES_ITER_CTR_EN
    ctr_load  = 1'b0;
    ctr_iv    = '0;
`endif

    expand_key(256, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    for (int r = 0; r < 16; r++) begin
      if (r <= c_NR256) ks256[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
      else              ks256[r] = '0;
    end
    expand_key(128, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    for (int r = 0; r < 16; r++) begin
      if (r <= c_NR128) ks128[r] = {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]};
      else              ks128[r] = '0;
    end

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_block", out_block0, 0);
    chk("rst_rk_idx", rk_idx0, 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 2'b11);

    // AES-256 known answer
    run_block(0, c_PT, res, lat);
    chk("aes256_ct", res, c_CT256);
    chk("aes256_latency", lat, c_NR256 + 1);
    chk("done_in_ready", in_ready[0], 0);
    chk("done_busy", busy[0], 1);
    chk("done_rk_idx", rk_idx0, 0);
    handshake();
    chk("after_hs_idle", {rk_idx0, busy[0], in_ready[0], out_valid[0]}, {4'd0, 3'b010});

    // AES-128 known answer
    run_block(1, c_PT, res, lat);
    chk("aes128_ct", res, c_CT128);
    chk("aes128_latency", lat, c_NR128 + 1);
    handshake();

    // Backpressure in DONE with a second block offered
    run_block(0, c_PT, res, lat);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) start_block(0, 128'hdeadbeef0123456789abcdeffedcba98);
      if (i == 12) drop();
      tick();
      chk("bp_out_block", out_block0, c_CT256);
      chk("bp_in_ready", {out_valid[0], in_ready[0]}, 2'b10);
    end
    handshake();
    chk("bp_second_not_taken", {busy[0], in_ready[0]}, 2'b01);

    // Asynchronous reset in round 7
    start_block(0, c_PT);
    tick();
    drop();
    seen = 0;
    while (rk_idx0 != 4'd7 && seen < 30) begin
      tick();
      seen++;
    end
    chk("pre_rst_rk_idx", rk_idx0, 7);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy[0], 0);
    chk("arst_rk_idx", rk_idx0, 0);
    chk("arst_out_block", out_block0, 0);
    chk("arst_out_valid", out_valid[0], 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid[0]) seen = 1;
    end
    chk("arst_no_out_valid", seen, 0);
    chk("arst_in_ready", in_ready[0], 1);
    run_block(0, c_PT, res, lat);
    chk("arst_next_ct", res, c_CT256);
    chk("arst_next_latency", lat, c_NR256 + 1);
    handshake();

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    start_block(0, c_PT);
    n_out = 0;
    for (int c = 0; c < 3 * (c_NR256 + 2) + 4; c++) begin
      if (in_valid[0] && in_ready[0]) acc.push_back(c);
      if (out_valid[0]) begin
        n_out++;
        chk("b2b_ct", out_block0, c_CT256);
      end
      tick();
    end
    drop();
    chk("b2b_accept_count", acc.size(), 4);
    chk("b2b_result_count", n_out, 3);
    for (int i = 0; i + 1 < acc.size(); i++)
      chk("b2b_spacing", acc[i+1] - acc[i], c_NR256 + 2);
    repeat (20) tick();
    out_ready = 1'b0;

`ifdef AES_ITER_CTR_EN
    begin
      logic [127:0] o1, o2, o3, o4, oz, oz2;
      logic [95:0]  u;
      logic [127:0] x1, x2;
      u  = 96'h0f1e2d3c4b5a69788796a5b4;
      x1 = 128'h0123456789abcdef0011223344556677;
      x2 = 128'hfedcba98765432108899aabbccddeeff;

      // Counter resets to zero
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      run_ctr(1'b0, '0, '0, oz);
      run_ctr(1'b1, '0, '0, oz2);
      chk("ctr_reset_zero", oz, oz2);

      // Known counter value XORed with data
      run_ctr(1'b1, c_PT, x1, res);
      chk("ctr_known", res, c_CT256 ^ x1);

      // Low-word wrap across two blocks
      run_ctr(1'b1, {u, 32'hffffffff}, x1, o1);
      run_ctr(1'b0, '0, x2, o2);
      run_ctr(1'b1, {u, 32'hffffffff}, '0, o3);
      chk("ctr_first_block", o1, o3 ^ x1);

      // Reference for wrapped counter, with a load while busy
      ctr_load = 1'b1;
      ctr_iv   = {u, 32'h00000000};
      in_block = '0;
      in_valid[0] = 1'b1;
      tick();
      drop();
      repeat (3) tick();
      ctr_load = 1'b1;
      ctr_iv   = c_PT;
      tick();
      ctr_load = 1'b0;
      seen = 0;
      while (!out_valid[0] && seen < 40) begin
        tick();
        seen++;
      end
      o4 = out_block0;
      handshake();
      chk("ctr_wrap_block", o2, o4 ^ x2);
      run_ctr(1'b0, '0, '0, res);
      chk("ctr_load_while_busy", res, c_CT256);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
